dff_resp_checker: RTL and testbench

- Response-side checker for the three-flavour D flip-flop block: plain, synchronous-reset and asynchronous-reset outputs.
- Observes the same D and DUT-reset stimulus that drives the flop block and runs a cycle-accurate reference model.
- Compares all three DUT outputs every clock and reports sticky errors, a mismatch count and first-failure capture.
- Synthesisable; instantiated next to the flop block for self-checking.

---
 rtl/dff_resp_checker.sv | 138 +++++++++++++
 tb/tb_dff_resp_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_resp_checker.sv
// Response checker for the plain / sync-reset / async-reset flop block.
// Optional stop-on-first-error behaviour: define DFF_CHK_STOP_ON_ERR_EN.
module dff_resp_checker #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             dut_reset_i,
  input  logic             d_i,
  input  logic             q_i,
  input  logic             q_syncrst_i,
  input  logic             q_asynrst_i,
  output logic             valid_o,
  output logic             err_o,
  output logic [2:0]       err_vec_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [CYC_W-1:0] cyc_cnt_o,
  output logic [CYC_W-1:0] first_err_cyc_o,
  output logic [2:0]       first_err_src_o
);

  localparam int unsigned SUM_W = CNT_W + 2;

`ifdef DFF_CHK_STOP_ON_ERR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_CHECK, ST_HALT} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_CHECK} state_e;
`endif

  state_e state_q, state_d;

  logic             exp_q_q, exp_s_q, exp_a_q;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] fcyc_q, fcyc_d;
  logic [2:0]       fsrc_q, fsrc_d;

  logic             e_a_c;
  logic [2:0]       m_c;
  logic [1:0]       pop_c;
  logic [SUM_W-1:0] msum_c;

  // Next-state and checker bookkeeping
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    vec_d   = vec_q;
    mcnt_d  = mcnt_q;
    cyc_d   = cyc_q;
    fcyc_d  = fcyc_q;
    fsrc_d  = fsrc_q;

    // An async reset asserted before the edge already forces the DUT output low
    e_a_c  = dut_reset_i ? 1'b0 : exp_a_q;
    m_c    = {q_asynrst_i != e_a_c, q_syncrst_i != exp_s_q, q_i != exp_q_q};
    pop_c  = {1'b0, m_c[0]} + {1'b0, m_c[1]} + {1'b0, m_c[2]};
    msum_c = {2'b00, mcnt_q} + SUM_W'(pop_c);

    case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        state_d = en_i ? ST_CHECK : ST_IDLE;
      end
      ST_CHECK: begin
        if (!en_i) state_d = ST_IDLE;
        if (cyc_q != {CYC_W{1'b1}}) cyc_d = cyc_q + CYC_W'(1);
        if (m_c != 3'b000) begin
          err_d = 1'b1;
          vec_d = vec_q | m_c;
          if (msum_c[SUM_W-1 -: 2] != 2'b00) mcnt_d = {CNT_W{1'b1}};
          else                               mcnt_d = msum_c[CNT_W-1:0];
          if (!err_q) begin
            fcyc_d = cyc_q;
            fsrc_d = m_c;
`ifdef DFF_CHK_STOP_ON_ERR_EN
            state_d = ST_HALT;
`endif
          end
        end
      end
`ifdef DFF_CHK_STOP_ON_ERR_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_CHECK);
  end

  // State, reference model and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      exp_q_q <= 1'b0;
      exp_s_q <= 1'b0;
      exp_a_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      vec_q   <= 3'b000;
      mcnt_q  <= '0;
      cyc_q   <= '0;
      fcyc_q  <= '0;
      fsrc_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      exp_q_q <= d_i;
      exp_s_q <= dut_reset_i ? 1'b0 : d_i;
      exp_a_q <= dut_reset_i ? 1'b0 : d_i;
      valid_q <= valid_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      mcnt_q  <= mcnt_d;
      cyc_q   <= cyc_d;
      fcyc_q  <= fcyc_d;
      fsrc_q  <= fsrc_d;
    end
  end

  assign valid_o         = valid_q;
  assign err_o           = err_q;
  assign err_vec_o       = vec_q;
  assign mismatch_cnt_o  = mcnt_q;
  assign cyc_cnt_o       = cyc_q;
  assign first_err_cyc_o = fcyc_q;
  assign first_err_src_o = fsrc_q;

endmodule

// File: tb/tb_dff_resp_checker.sv
// Directed self-checking bench for dff_resp_checker, driven by a behavioural flop block
// whose outputs can be corrupted per cycle. Expectations follow DFF_CHK_STOP_ON_ERR_EN.
module tb_dff_resp_checker;

`ifdef DFF_CHK_STOP_ON_ERR_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic        dut_reset;
  logic        d;
  logic [2:0]  inj;
  logic        hold_a;
  logic        fq, fs, fa;
  logic        q, qs, qa;

  logic        valid, err;
  logic [2:0]  vec, fsrc;
  logic [7:0]  mcnt;
  logic [15:0] cyc, fcyc;

  logic        valid2, err2;
  logic [2:0]  vec2, fsrc2;
  logic [1:0]  mcnt2;
  logic [15:0] cyc2, fcyc2;

  int checks = 0;
  int errors = 0;

  dff_resp_checker #(.CNT_W(8), .CYC_W(16)) u_dut (
    .clk(clk), .reset(reset), .en_i(en), .dut_reset_i(dut_reset), .d_i(d),
    .q_i(q), .q_syncrst_i(qs), .q_asynrst_i(qa),
    .valid_o(valid), .err_o(err), .err_vec_o(vec), .mismatch_cnt_o(mcnt),
    .cyc_cnt_o(cyc), .first_err_cyc_o(fcyc), .first_err_src_o(fsrc)
  );

  dff_resp_checker #(.CNT_W(2), .CYC_W(16)) u_dut_sat (
    .clk(clk), .reset(reset), .en_i(en), .dut_reset_i(dut_reset), .d_i(d),
    .q_i(q), .q_syncrst_i(qs), .q_asynrst_i(qa),
    .valid_o(valid2), .err_o(err2), .err_vec_o(vec2), .mismatch_cnt_o(mcnt2),
    .cyc_cnt_o(cyc2), .first_err_cyc_o(fcyc2), .first_err_src_o(fsrc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural flop block under observation
  always @(posedge clk) fq <= d;
  always @(posedge clk) fs <= dut_reset ? 1'b0 : d;
  always @(posedge clk or posedge dut_reset) begin
    if (dut_reset) fa <= 1'b0;
    else           fa <= d;
  end

  assign q  = fq ^ inj[0];
  assign qs = fs ^ inj[1];
  assign qa = hold_a ? 1'b1 : (fa ^ inj[2]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: toggle D, corrupt the selected outputs across the next posedge
  task automatic step(input logic [2:0] inj_v);
    d   = ~d;
    inj = inj_v;
    @(negedge clk);
    inj = 3'b000;
  endtask

  // DUT reset pulse straddling the posedge; optionally keep the async output stuck high
  task automatic pulse(input logic hold);
    d = ~d;
    #3;
    dut_reset = 1'b1;
    hold_a    = hold;
    #5;
    dut_reset = 1'b0;
    hold_a    = 1'b0;
    @(negedge clk);
  endtask

  task automatic restart();
    reset = 1'b1;
    en    = 1'b1;
    step(3'b000);
    step(3'b000);
    reset = 1'b0;
    step(3'b000);
    step(3'b000);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; dut_reset = 1'b0; d = 1'b0; inj = 3'b000; hold_a = 1'b0;

    // Reset held two cycles with enable high
    step(3'b000);
    step(3'b000);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_vec",   32'(vec),   32'd0);
    chk("rst_mcnt",  32'(mcnt),  32'd0);
    chk("rst_cyc",   32'(cyc),   32'd0);
    chk("rst_fcyc",  32'(fcyc),  32'd0);
    chk("rst_fsrc",  32'(fsrc),  32'd0);
    reset = 1'b0;
    step(3'b000);
    chk("prime_valid", 32'(valid), 32'd0);
    step(3'b000);
    chk("check_valid", 32'(valid), 32'd1);

    // Clean run
    for (int i = 0; i < 20; i++) step(3'b000);
    chk("clean_err",  32'(err),  32'd0);
    chk("clean_mcnt", 32'(mcnt), 32'd0);
    chk("clean_cyc",  32'(cyc),  32'd20);

    // Single sync-reset fault at checked cycle 5
    restart();
    for (int i = 0; i < 5; i++) step(3'b000);
    step(3'b010);
    for (int i = 0; i < 4; i++) step(3'b000);
    chk("t3_err",   32'(err),   32'd1);
    chk("t3_vec",   32'(vec),   32'b010);
    chk("t3_fcyc",  32'(fcyc),  32'd5);
    chk("t3_fsrc",  32'(fsrc),  32'b010);
    chk("t3_mcnt",  32'(mcnt),  32'd1);
    chk("t3_cyc",   32'(cyc),   HALT ? 32'd6 : 32'd10);
    chk("t3_valid", 32'(valid), HALT ? 32'd0 : 32'd1);

    // All three wrong at cycle 2, q alone at cycle 5; narrow counter saturates
    restart();
    step(3'b000);
    step(3'b000);
    step(3'b111);
    step(3'b000);
    step(3'b000);
    step(3'b001);
    step(3'b000);
    chk("t4_mcnt",  32'(mcnt),  HALT ? 32'd3 : 32'd4);
    chk("t4_vec",   32'(vec),   32'b111);
    chk("t4_fsrc",  32'(fsrc),  32'b111);
    chk("t4_fcyc",  32'(fcyc),  32'd2);
    chk("t4_mcnt2", 32'(mcnt2), 32'd3);
    for (int i = 0; i < 3; i++) step(3'b001);
    chk("t4_mcnt_more",  32'(mcnt),  HALT ? 32'd3 : 32'd7);
    chk("t4_mcnt2_sat",  32'(mcnt2), 32'd3);

    // DUT reset pulse around an edge, correct and stuck async output
    restart();
    step(3'b000);
    step(3'b000);
    pulse(1'b0);
    for (int i = 0; i < 3; i++) step(3'b000);
    chk("t5_ok_err", 32'(err), 32'd0);
    chk("t5_ok_cyc", 32'(cyc), 32'd6);
    pulse(1'b1);
    step(3'b000);
    step(3'b000);
    chk("t5_bad_vec",  32'(vec),  32'b100);
    chk("t5_bad_fsrc", 32'(fsrc), 32'b100);
    chk("t5_bad_fcyc", 32'(fcyc), 32'd6);
    chk("t5_bad_mcnt", 32'(mcnt), 32'd1);

    // Error at cycle 3, then enable toggling
    restart();
    for (int i = 0; i < 3; i++) step(3'b000);
    step(3'b010);
    chk("t6a_cyc",   32'(cyc),   32'd4);
    chk("t6a_valid", 32'(valid), HALT ? 32'd0 : 32'd1);
    chk("t6a_fcyc",  32'(fcyc),  32'd3);
    chk("t6a_mcnt",  32'(mcnt),  32'd1);
    en = 1'b0;
    step(3'b000);
    chk("t6b_cyc",   32'(cyc),   HALT ? 32'd4 : 32'd5);
    chk("t6b_valid", 32'(valid), 32'd0);
    step(3'b001);
    en = 1'b1;
    step(3'b001);
    step(3'b001);
    chk("t6c_valid", 32'(valid), HALT ? 32'd0 : 32'd1);
    chk("t6c_cyc",   32'(cyc),   HALT ? 32'd4 : 32'd5);
    chk("t6c_mcnt",  32'(mcnt),  32'd1);
    chk("t6c_vec",   32'(vec),   32'b010);
    step(3'b001);
    chk("t6d_mcnt", 32'(mcnt), HALT ? 32'd1 : 32'd2);
    chk("t6d_vec",  32'(vec),  HALT ? 32'b010 : 32'b011);
    chk("t6d_cyc",  32'(cyc),  HALT ? 32'd4 : 32'd6);
    chk("t6d_fsrc", 32'(fsrc), 32'b010);
    chk("t6d_fcyc", 32'(fcyc), 32'd3);
    restart();
    chk("t6e_valid", 32'(valid), 32'd1);
    chk("t6e_err",   32'(err),   32'd0);
    chk("t6e_cyc",   32'(cyc),   32'd0);
    chk("t6e_vec",   32'(vec),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
